lcd_debug_display: RTL and testbench

Character-LCD driver for the board-level debug path. Consumes the processor top level's selected debug word, current PC and output-select code, and continuously renders them as uppercase hex on a 16x2 HD44780-compatible LCD in 8-bit write-only mode. It owns the power-up init sequence, enable-pulse timing and per-frame snapshotting, so display values are never torn mid-frame.

---
 rtl/lcd_debug_display.sv | 254 +++++++++++++++++++++++++
 tb/tb_lcd_debug_display.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_debug_display.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_debug_display
//  Purpose  : Renders the selected debug word, PC and output-select code as
//             uppercase hex on a 16x2 HD44780 character LCD (8-bit, write
//             only). Owns power-up delay, init commands, enable timing and
//             per-frame snapshotting of the displayed values.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_debug_display #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int EN_CYCLES    = 16,
  parameter int CMD_WAIT     = 2500,
  parameter int CLR_WAIT     = 100000
) (
  input  logic        CLOCK_50,
  input  logic        SYS_reset,
  input  logic [31:0] disp_value,
  input  logic [31:0] disp_pc,
  input  logic [7:0]  disp_sel,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        ready,
  output logic        frame_done
);

  // One shared counter covers power-up, strobe and both post-write waits.
  localparam int MAX_A   = (PWRUP_CYCLES > CLR_WAIT) ? PWRUP_CYCLES : CLR_WAIT;
  localparam int MAX_B   = (EN_CYCLES > CMD_WAIT) ? EN_CYCLES : CMD_WAIT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [5:0] INIT_LAST_IDX  = 6'd3;
  localparam logic [5:0] FRAME_LAST_IDX = 6'd33;

  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_INIT  = 2'd1,
    ST_LATCH = 2'd2,
    ST_FRAME = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SL_SETUP  = 2'd0,
    SL_STROBE = 2'd1,
    SL_WAIT   = 2'd2
  } slot_t;

  state_t           state_q, state_d;
  slot_t            slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [31:0]      pc_q, pc_d;
  logic [7:0]       sel_q, sel_d;
  logic [31:0]      val_q, val_d;

  logic [CNT_W-1:0] w_wait_last;
  logic [5:0]       w_next_idx;
  logic [8:0]       w_next_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // {RS, DATA} for write number idx of the init sequence or of a frame.
  function automatic logic [8:0] slot_byte(input logic        is_init,
                                           input logic [5:0]  idx,
                                           input logic [31:0] pc,
                                           input logic [7:0]  sel,
                                           input logic [31:0] val);
    logic [8:0] r;
    int         k;
    r = 9'h000;
    k = 0;
    if (is_init) begin
      case (idx[1:0])
        2'd0:    r = {1'b0, 8'h38};
        2'd1:    r = {1'b0, 8'h0C};
        2'd2:    r = {1'b0, 8'h01};
        default: r = {1'b0, 8'h06};
      endcase
    end else if (idx == 6'd0) begin
      r = {1'b0, 8'h80};
    end else if (idx == 6'd17) begin
      r = {1'b0, 8'hC0};
    end else if (idx < 6'd17) begin
      // Line 1: "PC " + 8 hex of pc + " S:" + 2 hex of sel
      k = int'(idx) - 1;
      if      (k == 0)  r = {1'b1, 8'h50};
      else if (k == 1)  r = {1'b1, 8'h43};
      else if (k == 2)  r = {1'b1, 8'h20};
      else if (k <= 10) r = {1'b1, hex_ascii(pc[4*(10-k) +: 4])};
      else if (k == 11) r = {1'b1, 8'h20};
      else if (k == 12) r = {1'b1, 8'h53};
      else if (k == 13) r = {1'b1, 8'h3A};
      else if (k == 14) r = {1'b1, hex_ascii(sel[7:4])};
      else              r = {1'b1, hex_ascii(sel[3:0])};
    end else begin
      // Line 2: "VAL " + 8 hex of value + 4 spaces
      k = int'(idx) - 18;
      if      (k == 0)  r = {1'b1, 8'h56};
      else if (k == 1)  r = {1'b1, 8'h41};
      else if (k == 2)  r = {1'b1, 8'h4C};
      else if (k == 3)  r = {1'b1, 8'h20};
      else if (k <= 11) r = {1'b1, hex_ascii(val[4*(11-k) +: 4])};
      else              r = {1'b1, 8'h20};
    end
    return r;
  endfunction

  assign w_wait_last = ((data_q == 8'h01) && !rs_q) ? CLR_LAST : CMD_LAST;
  assign w_next_idx  = idx_q + 6'd1;
  assign w_next_byte = slot_byte(state_q == ST_INIT, w_next_idx, pc_q, sel_q, val_q);

  // State, slot counter and bus registers; reset clears EN immediately.
  always_ff @(posedge CLOCK_50 or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= ST_PWRUP;
      slot_q  <= SL_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      sel_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
    end
  end

  // Next-state logic: top sequencer plus the shared write-slot sub-FSM.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    pc_d    = pc_q;
    sel_d   = sel_q;
    val_d   = val_q;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = ST_INIT;
          slot_d  = SL_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          data_d  = 8'h38;
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LATCH: begin
        // Snapshot so a frame is never rendered from mixed input values.
        pc_d    = disp_pc;
        sel_d   = disp_sel;
        val_d   = disp_value;
        state_d = ST_FRAME;
        slot_d  = SL_SETUP;
        cnt_d   = '0;
        idx_d   = '0;
        data_d  = 8'h80;
        rs_d    = 1'b0;
      end

      default: begin
        case (slot_q)
          SL_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
              slot_d = SL_STROBE;
              cnt_d  = '0;
              en_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          SL_STROBE: begin
            if (cnt_q == EN_LAST) begin
              slot_d = SL_WAIT;
              cnt_d  = '0;
              en_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            if (cnt_q == w_wait_last) begin
              cnt_d = '0;
              if ((state_q == ST_INIT) && (idx_q == INIT_LAST_IDX)) begin
                state_d = ST_LATCH;
                ready_d = 1'b1;
              end else if ((state_q == ST_FRAME) && (idx_q == FRAME_LAST_IDX)) begin
                state_d = ST_LATCH;
                done_d  = 1'b1;
              end else begin
                idx_d  = w_next_idx;
                slot_d = SL_SETUP;
                rs_d   = w_next_byte[8];
                data_d = w_next_byte[7:0];
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        endcase
      end
    endcase
  end

  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = en_q;
  assign ready      = ready_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_debug_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_debug_display
//  Purpose  : Scoreboard bench for lcd_debug_display. Expected LCD writes are
//             built from display strings and queued; a bus monitor decodes
//             every EN pulse and checks it against the queue and bus timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lcd_debug_display;

  localparam int PWRUP_CYCLES = 20;
  localparam int EN_CYCLES    = 4;
  localparam int CMD_WAIT     = 10;
  localparam int CLR_WAIT     = 30;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [7:0]  sel;
  logic [31:0] val;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, ready, frame_done;

  lcd_debug_display #(
    .PWRUP_CYCLES(PWRUP_CYCLES),
    .EN_CYCLES   (EN_CYCLES),
    .CMD_WAIT    (CMD_WAIT),
    .CLR_WAIT    (CLR_WAIT)
  ) dut (
    .CLOCK_50  (clk),
    .SYS_reset (rst),
    .disp_value(val),
    .disp_pc   (pc),
    .disp_sel  (sel),
    .LCD_DATA  (LCD_DATA),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_EN    (LCD_EN),
    .ready     (ready),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: text rendering of the display, pushed as {RS, byte}.
  function automatic string hexs(input logic [31:0] v, input int n);
    string digits;
    string s;
    int    d;
    digits = "0123456789ABCDEF";
    s = "";
    for (int i = n - 1; i >= 0; i--) begin
      d = int'((v >> (4 * i)) & 32'hF);
      s = {s, digits.substr(d, d)};
    end
    return s;
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, 8'(s[i])});
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [7:0] s, input logic [31:0] v);
    exp_q.push_back(9'h080);
    push_str({"PC ", hexs(p, 8), " S:", hexs({24'h0, s}, 2)});
    exp_q.push_back(9'h0C0);
    push_str({"VAL ", hexs(v, 8), "    "});
  endtask

  // Bus monitor: decodes writes, checks timing and pops the scoreboard.
  int         wr_cnt, en_w, gap;
  logic       have_fall, latch_seen, last_clear;
  logic       p_en, p_rs, p_ready;
  logic [7:0] p_data;
  int         exp_gap;

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0; en_w = 0; gap = 0;
      have_fall = 1'b0; latch_seen = 1'b0; last_clear = 1'b0;
      p_en = 1'b0; p_rs = 1'b0; p_ready = 1'b0; p_data = 8'h00;
    end else begin
      check("rw_low", {63'h0, LCD_RW}, 64'h0);
      if (LCD_EN && p_en)
        check("bus_stable", {55'h0, LCD_RS, LCD_DATA}, {55'h0, p_rs, p_data});
      if (LCD_EN && !p_en) begin
        if (have_fall) begin
          exp_gap = (last_clear ? CLR_WAIT : CMD_WAIT) + 2 + (latch_seen ? 1 : 0);
          check("en_gap", 64'(gap), 64'(exp_gap));
        end
        if (exp_q.size() == 0) begin
          check("sb_empty", {55'h0, LCD_RS, LCD_DATA}, 64'h1FF_0000);
        end else begin
          check("write", {55'h0, LCD_RS, LCD_DATA}, {55'h0, exp_q.pop_front()});
        end
        en_w = 1;
        wr_cnt++;
        latch_seen = 1'b0;
      end else if (LCD_EN) begin
        en_w++;
      end
      if (!LCD_EN && p_en) begin
        check("en_width", 64'(en_w), 64'(EN_CYCLES));
        have_fall  = 1'b1;
        gap        = 1;
        last_clear = (p_data == 8'h01) && !p_rs;
      end else if (!LCD_EN && have_fall) begin
        gap++;
      end
      if (frame_done) begin
        check("frame_len", 64'(wr_cnt), 64'd34);
        wr_cnt = 0;
        latch_seen = 1'b1;
      end
      if (ready && !p_ready) begin
        check("init_len", 64'(wr_cnt), 64'd4);
        wr_cnt = 0;
        latch_seen = 1'b1;
      end
      if (p_ready) check("ready_hold", {63'h0, ready}, 64'h1);
      p_en = LCD_EN; p_rs = LCD_RS; p_data = LCD_DATA; p_ready = ready;
    end
  end

  // Release reset at a falling edge; outputs must stay idle for PWRUP_CYCLES.
  task automatic release_and_check_pwrup();
    int n;
    rst = 1'b0;
    for (int i = 0; i < PWRUP_CYCLES; i++) begin
      if (i > 0) @(negedge clk);
      check("pwrup_idle", {52'h0, LCD_EN, LCD_RS, LCD_DATA, ready, frame_done}, 64'h0);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!LCD_EN && n < 50);
    check("first_en", 64'(PWRUP_CYCLES - 1 + n), 64'(PWRUP_CYCLES + 2));
  endtask

  // Returns during the LATCH cycle (ready just rose, or frame_done high).
  task automatic wait_latch();
    int   n;
    logic r0;
    r0 = ready;
    n  = 0;
    forever begin
      @(negedge clk);
      n++;
      if (frame_done || (ready && !r0)) break;
      r0 = ready;
      if (n > 3000) begin
        check("latch_timeout", 64'(n), 64'h0);
        break;
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pc  = 32'h00400A3C;
    sel = 8'h07;
    val = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check("reset_state", {52'h0, LCD_EN, LCD_RS, LCD_DATA, ready, frame_done}, 64'h0);
    push_init();
    release_and_check_pwrup();

    for (int f = 0; f < 5; f++) begin
      wait_latch();
      push_frame(pc, sel, val);
      if (f == 4) break;
      repeat (60) @(negedge clk);
      case (f)
        0: val = 32'h12345678;
        1: begin pc = 32'hFFFFFFFF; sel = 8'hAF; end
        default: begin pc = $urandom; sel = 8'($urandom); val = $urandom; end
      endcase
    end

    // Reset in the middle of a character strobe.
    n = 0;
    while (!(LCD_EN && LCD_RS) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("found_char_strobe", {63'h0, LCD_EN && LCD_RS}, 64'h1);
    #1 rst = 1'b1;
    #1 check("async_en_drop", {62'h0, LCD_EN, ready}, 64'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_init();
    pc = $urandom; sel = 8'($urandom); val = $urandom;
    release_and_check_pwrup();
    wait_latch();
    check("ready_after_reinit", {63'h0, ready}, 64'h1);
    push_frame(pc, sel, val);
    repeat (60) @(negedge clk);
    pc = $urandom; val = $urandom;
    wait_latch();
    check("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
